// File: rtl/sha512_pkg.sv
// Shared types and constants for the SHA-512 front end.
// Contents: block/half-block types, padder FSM state enum, padding constants.
package sha512_pkg;

  localparam int unsigned SHA512_BLK_W      = 1024;
  localparam int unsigned SHA512_HALF_W     = 512;
  localparam int unsigned SHA512_SLOT_BYTES = 64;
  localparam int unsigned SHA512_LEN_BYTES  = 16;
  localparam logic [7:0]  SHA512_PAD_BYTE   = 8'h80;

  typedef logic [SHA512_BLK_W-1:0]  t_sha_block;
  typedef logic [SHA512_HALF_W-1:0] t_sha_half;

  typedef enum logic [1:0] {
    S_PAD_IDLE,
    S_PAD_LO,
    S_PAD_HI,
    S_PAD_EMIT
  } t_pad_state;

endpackage

// File: rtl/sha512_slot_fmt.sv
// Formats one 64-byte slot of a padded SHA-512 block (combinational).
// Ports:
//   line       : input cache line, message byte i at [8i+7:8i]
//   rem_bytes  : message bytes remaining at this slot, clamped to 64
//   pad_only   : slot carries no message data (no line consumed)
//   pad_mark   : 0x80 terminator not yet emitted; place it at p == rem_bytes
//   final_slot : last slot of the message; low 16 bytes carry bit_len
//   bit_len    : 128-bit message length in bits
//   half_c     : formatted half-block, slot byte p at [511-8p -: 8]
module sha512_slot_fmt
  import sha512_pkg::*;
(
  input  logic [SHA512_HALF_W-1:0]      line,
  input  logic [6:0]                    rem_bytes,
  input  logic                          pad_only,
  input  logic                          pad_mark,
  input  logic                          final_slot,
  input  logic [8*SHA512_LEN_BYTES-1:0] bit_len,
  output logic [SHA512_HALF_W-1:0]      half_c
);

  // Byte-swap message data into big-endian order, zero the tail, mark the end.
  always_comb begin
    half_c = '0;
    for (int p = 0; p < SHA512_SLOT_BYTES; p++) begin
      if (!pad_only && (7'(p) < rem_bytes)) begin
        half_c[SHA512_HALF_W-1-8*p -: 8] = line[8*p +: 8];
      end else if (pad_mark && (7'(p) == rem_bytes)) begin
        half_c[SHA512_HALF_W-1-8*p -: 8] = SHA512_PAD_BYTE;
      end
    end
    // Slot bytes 48..63 land exactly in the low 128 bits, MSB first.
    if (final_slot) begin
      half_c[8*SHA512_LEN_BYTES-1:0] = bit_len;
    end
  end

endmodule

// File: rtl/sha512_padder.sv
// FIPS 180-4 SHA-512 message padder: turns a byte length plus a stream of
// 64-byte cache lines into padded 1024-bit big-endian message blocks.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, len          : begin a message of len bytes (accepted only when idle)
//   line_valid/ready    : input line handshake, line_data byte i at [8i+7:8i]
//   blk_valid/ready     : output block handshake, blk_data byte j at [1023-8j -: 8]
//   blk_last            : current block is the final one of the message
//   busy, done          : message in progress / one-cycle completion pulse
module sha512_padder
  import sha512_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     line_valid,
  input  logic [SHA512_HALF_W-1:0] line_data,
  output logic                     line_ready,
  output logic                     blk_valid,
  output logic [SHA512_BLK_W-1:0]  blk_data,
  output logic                     blk_last,
  input  logic                     blk_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned SLOT_W = LEN_W - 5;
  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam int unsigned BL_W   = 8 * SHA512_LEN_BYTES;

  t_pad_state        state_q, state_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  rem_q, rem_n;       // message bytes not yet placed
  logic              pad_done_q, pad_done_n;
  logic [SLOT_W-1:0] slot_q, slot_n;
  logic [SLOT_W-1:0] last_slot_q, last_slot_n;
  logic              line_ready_n, blk_valid_n, blk_last_n, busy_n, done_n;
  logic              wr_lo, wr_hi, advance, data_slot, is_final;

  logic [CNT_W-1:0]      nb_c;
  logic [SLOT_W-1:0]     last_slot_c;
  logic [6:0]            rem_bytes_c;
  logic [BL_W-1:0]       bit_len_c;
  logic [SHA512_HALF_W-1:0] half_c;

  // Number of blocks and index of the final 64-byte slot for the incoming length.
  always_comb begin
    nb_c        = ((CNT_W'(len) + CNT_W'(SHA512_LEN_BYTES)) >> 7) + CNT_W'(1);
    last_slot_c = SLOT_W'({nb_c, 1'b0} - (CNT_W+1)'(1));
  end

  assign data_slot   = (rem_q != '0);
  assign is_final    = (slot_q == last_slot_q);
  assign rem_bytes_c = (rem_q >= LEN_W'(SHA512_SLOT_BYTES)) ? 7'(SHA512_SLOT_BYTES) : 7'(rem_q);
  assign bit_len_c   = BL_W'({len_q, 3'b000});

  sha512_slot_fmt u_fmt (
    .line       (line_data),
    .rem_bytes  (rem_bytes_c),
    .pad_only   (!data_slot),
    .pad_mark   (!pad_done_q),
    .final_slot (is_final),
    .bit_len    (bit_len_c),
    .half_c     (half_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    len_n       = len_q;
    rem_n       = rem_q;
    pad_done_n  = pad_done_q;
    slot_n      = slot_q;
    last_slot_n = last_slot_q;
    busy_n      = busy;
    done_n      = 1'b0;
    blk_last_n  = blk_last;
    wr_lo       = 1'b0;
    wr_hi       = 1'b0;
    advance     = 1'b0;

    case (state_q)
      S_PAD_IDLE: begin
        if (start) begin
          state_n     = S_PAD_LO;
          len_n       = len;
          rem_n       = len;
          pad_done_n  = 1'b0;
          slot_n      = '0;
          last_slot_n = last_slot_c;
          busy_n      = 1'b1;
          blk_last_n  = 1'b0;
        end
      end
      S_PAD_LO, S_PAD_HI: begin
        // Data slots wait for a line; padding slots complete immediately.
        advance = data_slot ? (line_valid && line_ready) : 1'b1;
        if (advance) begin
          slot_n     = slot_q + SLOT_W'(1);
          rem_n      = (rem_q >= LEN_W'(SHA512_SLOT_BYTES)) ?
                       (rem_q - LEN_W'(SHA512_SLOT_BYTES)) : '0;
          // Terminator lands in this slot whenever fewer than 64 bytes remain.
          pad_done_n = pad_done_q | (rem_q < LEN_W'(SHA512_SLOT_BYTES));
          if (state_q == S_PAD_LO) begin
            wr_lo   = 1'b1;
            state_n = S_PAD_HI;
          end else begin
            wr_hi      = 1'b1;
            blk_last_n = is_final;
            state_n    = S_PAD_EMIT;
          end
        end
      end
      S_PAD_EMIT: begin
        if (blk_ready) begin
          if (blk_last) begin
            state_n = S_PAD_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = S_PAD_LO;
          end
        end
      end
      default: state_n = S_PAD_IDLE;
    endcase

    line_ready_n = ((state_n == S_PAD_LO) || (state_n == S_PAD_HI)) && (rem_n != '0);
    blk_valid_n  = (state_n == S_PAD_EMIT);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_PAD_IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      pad_done_q  <= 1'b0;
      slot_q      <= '0;
      last_slot_q <= '0;
      line_ready  <= 1'b0;
      blk_valid   <= 1'b0;
      blk_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      len_q       <= len_n;
      rem_q       <= rem_n;
      pad_done_q  <= pad_done_n;
      slot_q      <= slot_n;
      last_slot_q <= last_slot_n;
      line_ready  <= line_ready_n;
      blk_valid   <= blk_valid_n;
      blk_last    <= blk_last_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Block assembly register; contents are don't-care out of reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_lo) blk_data[SHA512_BLK_W-1:SHA512_HALF_W] <= half_c;
    if (!reset && wr_hi) blk_data[SHA512_HALF_W-1:0]            <= half_c;
  end

endmodule

// File: tb/tb_sha512_padder.sv
// Self-checking bench for sha512_padder: table of directed lengths, randomized
// messages, and hand sequences for reset mid-message.
module tb_sha512_padder;

  logic          clk;
  logic          reset;
  logic          start;
  logic [31:0]   len;
  logic          line_valid;
  logic [511:0]  line_data;
  logic          line_ready;
  logic          blk_valid;
  logic [1023:0] blk_data;
  logic          blk_last;
  logic          blk_ready;
  logic          busy;
  logic          done;

  sha512_padder #(.LEN_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .line_valid (line_valid),
    .line_data  (line_data),
    .line_ready (line_ready),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .blk_last   (blk_last),
    .blk_ready  (blk_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  byte unsigned msg   [0:1023];
  byte unsigned exp_b [0:1023];
  int unsigned  cur_len;
  int           mdl_nb;

  typedef struct {
    int unsigned len;
    int          mode;    // 0 random bytes, 1 all 0xAA, 2 "abc"
    int          rmode;   // 0 ready always, 1 random, 2 low for 5 valid cycles
    int          exp_nb;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: whole padded message as a flat byte array.
  task automatic build(input int unsigned L, input int mode);
    longint unsigned bits;
    int tot;
    cur_len = L;
    for (int i = 0; i < 1024; i++) begin
      msg[i] = 8'($urandom);
      if (mode == 1) msg[i] = 8'hAA;
    end
    if (mode == 2) begin
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    end
    mdl_nb = int'((L + 16) / 128) + 1;
    tot    = mdl_nb * 128;
    bits   = longint'(L) * 8;
    for (int j = 0; j < tot; j++) begin
      if (j < int'(L))       exp_b[j] = msg[j];
      else if (j == int'(L)) exp_b[j] = 8'h80;
      else                   exp_b[j] = 8'h00;
    end
    for (int i = 8; i < 16; i++) exp_b[tot-16+i] = 8'(bits >> (8 * (15 - i)));
  endtask

  function automatic logic [1023:0] exp_blk(input int b);
    logic [1023:0] r;
    for (int j = 0; j < 128; j++) r[1023-8*j -: 8] = exp_b[128*b+j];
    return r;
  endfunction

  // Line n of the message; bytes past the end are garbage the DUT must drop.
  function automatic logic [511:0] make_line(input int n);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) begin
      int idx = 64 * n + i;
      if (idx < int'(cur_len) && idx < 1024) r[8*i +: 8] = msg[idx];
      else                                   r[8*i +: 8] = 8'($urandom);
    end
    return r;
  endfunction

  task automatic chk_blk(input int b);
    logic [1023:0] want;
    want = exp_blk(b);
    total++;
    if (blk_data !== want) begin
      bad++;
      for (int j = 0; j < 128; j++) begin
        if (blk_data[1023-8*j -: 8] !== want[1023-8*j -: 8]) begin
          $display("FAIL blk_data len=%0d blk=%0d byte=%0d got=%0h want=%0h",
                   cur_len, b, j, blk_data[1023-8*j -: 8], want[1023-8*j -: 8]);
          break;
        end
      end
    end
  endtask

  task automatic run_msg(input int unsigned L, input int mode, input int rmode, input int exp_nb);
    int exp_lines, lines, blks, vcnt, over, cyc;
    bit fin;
    build(L, mode);
    exp_lines = int'((L + 63) / 64);
    lines = 0; blks = 0; vcnt = 0; over = 0; cyc = 0; fin = 0;
    @(negedge clk);
    start = 1'b1; len = L; line_valid = 1'b0; blk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    while (!fin && cyc < 4000) begin
      cyc++;
      line_valid = ($urandom_range(0, 3) != 0);
      line_data  = make_line(lines);
      case (rmode)
        0:       blk_ready = 1'b1;
        1:       blk_ready = ($urandom_range(0, 1) == 0);
        default: blk_ready = (vcnt >= 5);
      endcase
      start = ($urandom_range(0, 7) == 0);
      len   = $urandom;
      chk("done_low", 64'(done), 64'd0);
      chk("busy_high", 64'(busy), 64'd1);
      if (line_valid && line_ready) begin
        if (lines >= exp_lines) over++;
        lines++;
      end
      if (blk_valid) begin
        chk_blk(blks);
        chk("blk_last", 64'(blk_last), 64'(blks == mdl_nb - 1));
        vcnt++;
        if (blk_ready) begin
          if (blk_last) fin = 1;
          blks++;
          vcnt = 0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout len=%0d blocks=%0d lines=%0d", L, blks, lines);
    end else begin
      chk("done_pulse", 64'(done), 64'd1);
      chk("busy_clear", 64'(busy), 64'd0);
      chk("valid_clear", 64'(blk_valid), 64'd0);
      line_valid = 1'b1;
      @(negedge clk);
      chk("done_single", 64'(done), 64'd0);
      chk("ready_idle", 64'(line_ready), 64'd0);
    end
    line_valid = 1'b0;
    chk("lines_taken", 64'(lines), 64'(exp_lines));
    chk("lines_over", 64'(over), 64'd0);
    chk("block_count", 64'(blks), 64'(exp_nb));
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; line_valid = 1'b0;
    line_data = '0; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_line_ready", 64'(line_ready), 64'd0);
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_blk_last", 64'(blk_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    vecs.push_back('{0,    0, 0, 1});
    vecs.push_back('{3,    2, 0, 1});
    vecs.push_back('{111,  1, 0, 1});
    vecs.push_back('{112,  1, 1, 2});
    vecs.push_back('{128,  1, 2, 2});
    vecs.push_back('{1,    0, 0, 1});
    vecs.push_back('{64,   0, 1, 1});
    vecs.push_back('{127,  0, 1, 2});
    vecs.push_back('{239,  0, 2, 2});
    vecs.push_back('{240,  0, 1, 3});
    vecs.push_back('{1000, 0, 1, 8});
    foreach (vecs[i]) run_msg(vecs[i].len, vecs[i].mode, vecs[i].rmode, vecs[i].exp_nb);

    for (int i = 0; i < 8; i++) begin
      int unsigned rl;
      rl = $urandom_range(0, 1000);
      run_msg(rl, 0, int'($urandom_range(0, 2)), int'((rl + 16) / 128) + 1);
    end

    // Reset right after the first line handshake of a 200-byte message.
    begin
      int cyc;
      bit hs;
      build(200, 0);
      @(negedge clk);
      start = 1'b1; len = 32'd200;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; hs = 0;
      while (!hs && cyc < 100) begin
        cyc++;
        line_valid = 1'b1;
        line_data  = make_line(0);
        hs = line_ready;
        @(negedge clk);
      end
      chk("rst_test_hs", 64'(hs), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_line_ready", 64'(line_ready), 64'd0);
      chk("mid_rst_blk_valid", 64'(blk_valid), 64'd0);
      chk("mid_rst_blk_last", 64'(blk_last), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      for (int i = 0; i < 5; i++) begin
        line_data = make_line(1);
        @(negedge clk);
        chk("post_rst_line_ready", 64'(line_ready), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_valid", 64'(blk_valid), 64'd0);
      end
      line_valid = 1'b0;
      run_msg(3, 2, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
